// File: rtl/lfsr_tx_sched_pkg.sv
// Shared types and constants for the LFSR transmit scheduler.
// State encoding, default seed, K-character mask and preamble word.
package lfsr_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_PRBS = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_SEED     = 16'hA076;
    localparam logic [3:0]  K_MASK        = 4'b0101;
    localparam logic [31:0] PREAMBLE_WORD = 32'h50BC50BC;

endpackage

// File: rtl/lfsr_tx_sched_step.sv
// Combinational LFSR step: 16-bit state in, 32-bit word and next state out.
// Bits are produced MSB-first from a 48-bit window seeded with the state.
module lfsr_step (
    input  logic [15:0] i_state,
    output logic [31:0] o_word,
    output logic [15:0] o_next
);

    logic [47:0] w;

    always_comb begin
        w         = '0;
        w[47:32]  = i_state;
        for (int i = 0; i < 32; i++) begin
            w[31-i] = w[47-i] ^ w[46-i] ^ w[45-i] ^ w[33-i];
        end
    end

    assign o_word = w[31:0];
    assign o_next = w[15:0];

endmodule

// File: rtl/lfsr_tx_sched.sv
// Burst scheduler: preamble beats, PRBS words, idle gap, done pulse.
// All outputs registered; valid/ready handshake holds data across stalls.
module lfsr_tx_sched
    import lfsr_tx_sched_pkg::*;
#(
    parameter logic [15:0] P_LFSR_INIT     = LFSR_SEED,
    parameter logic [31:0] P_PREAMBLE_WORD = PREAMBLE_WORD,
    parameter int          P_PREAMBLE_CNT  = 2,
    parameter int          P_GAP_CYCLES    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_burst_len,
    input  logic        i_abort,
    output logic [31:0] o_tx_data,
    output logic [3:0]  o_tx_charisk,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_aborted
);

    localparam logic [15:0] PRE_LAST = 16'(P_PREAMBLE_CNT - 1);
    localparam logic [15:0] GAP_LAST = 16'(P_GAP_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  k_q, k_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;

    logic [31:0] step_word;
    logic [15:0] step_next;
    logic        accept;

    lfsr_step u_step (
        .i_state (lfsr_q),
        .o_word  (step_word),
        .o_next  (step_next)
    );

    assign accept = valid_q & i_tx_ready;

    // lfsr_q runs one step ahead: it advances as each PRBS word is loaded
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        data_d    = data_q;
        k_d       = k_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_PRE;
                    len_d   = i_burst_len;
                    lfsr_d  = P_LFSR_INIT;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    data_d  = P_PREAMBLE_WORD;
                    k_d     = K_MASK;
                end
            end
            ST_PRE: begin
                if (i_abort) begin
                    state_d = ST_GAP;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (cnt_q == PRE_LAST) begin
                        cnt_d = '0;
                        if (len_q != 16'd0) begin
                            state_d = ST_PRBS;
                            lfsr_d  = step_next;
                            data_d  = step_word;
                            k_d     = 4'h0;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            ST_PRBS: begin
                if (i_abort) begin
                    state_d = ST_GAP;
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else if (accept) begin
                    if (cnt_q == len_q - 16'd1) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d  = cnt_q + 16'd1;
                        lfsr_d = step_next;
                        data_d = step_word;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    done_d    = 1'b1;
                    aborted_d = abort_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        valid_d = (state_d == ST_PRE) || (state_d == ST_PRBS);
        busy_d  = (state_d != ST_IDLE);
        if (!valid_d) begin
            data_d = '0;
            k_d    = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= P_LFSR_INIT;
            len_q     <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            data_q    <= '0;
            k_q       <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            data_q    <= data_d;
            k_q       <= k_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign o_tx_data    = data_q;
    assign o_tx_charisk = k_q;
    assign o_tx_valid   = valid_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_aborted    = aborted_q;

endmodule

// File: tb/tb_lfsr_tx_sched.sv
// Directed bench for lfsr_tx_sched with a reference LFSR model.
// Outputs sampled on the falling edge; inputs driven there too.
module tb_lfsr_tx_sched;

    localparam logic [31:0] PRE_W = 32'h50BC50BC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] burst_len;
    logic        abort;
    logic        ready;
    logic [31:0] tx_data;
    logic [3:0]  tx_k;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic        aborted;

    int nchk = 0;
    int nerr = 0;

    logic [31:0] g [0:4];
    logic [31:0] words [0:7];
    int          nw;
    int          bcnt;
    int          ndone;
    int          nidle;
    logic        stalled;
    logic        seen_done;
    logic [31:0] prev_d;
    logic [3:0]  prev_k;

    always #5 clk = ~clk;

    lfsr_tx_sched dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_burst_len  (burst_len),
        .i_abort      (abort),
        .o_tx_data    (tx_data),
        .o_tx_charisk (tx_k),
        .o_tx_valid   (tx_valid),
        .i_tx_ready   (ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_aborted    (aborted)
    );

    // Shift-register form of the recurrence: one new bit per step
    function automatic logic [47:0] ref_step(input logic [15:0] s);
        logic [15:0] win;
        logic [31:0] out;
        logic        b;
        win = s;
        out = '0;
        for (int k = 0; k < 32; k++) begin
            b   = win[15] ^ win[14] ^ win[13] ^ win[1];
            out = {out[30:0], b};
            win = {win[14:0], b};
        end
        return {out, win};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] d,
                               input logic [3:0] k);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
        chk({tag, "_data"}, tx_data, d);
        chk({tag, "_k"}, 32'(tx_k), 32'(k));
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, "_valid"}, 32'(tx_valid), 32'd0);
        chk({tag, "_data"}, tx_data, 32'd0);
        chk({tag, "_k"}, 32'(tx_k), 32'd0);
    endtask

    task automatic start_burst(input logic [15:0] l);
        start     = 1'b1;
        burst_len = l;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin
        logic [47:0] r;
        logic [15:0] s;
        s = 16'hA076;
        for (int i = 0; i < 5; i++) begin
            r    = ref_step(s);
            g[i] = r[47:16];
            s    = r[15:0];
        end

        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = '0;
        abort     = 1'b0;
        ready     = 1'b1;
        repeat (2) @(negedge clk);
        expect_idle("rst");
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_busy", 32'(busy), 32'd0);

        // len=3, ready high
        bcnt = 0;
        start_burst(16'd3);
        for (int c = 0; c < 10; c++) begin
            bcnt += int'(busy);
            if (c < 2) expect_beat("s1_pre", PRE_W, 4'b0101);
            else if (c < 5) expect_beat("s1_word", g[c-2], 4'h0);
            else expect_idle("s1_gap");
            chk("s1_done", 32'(done), (c == 9) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("s1_busy_end", 32'(busy), 32'd0);
        chk("s1_busy_cycles", 32'(bcnt), 32'd10);

        // len=0: preamble straight to gap
        start_burst(16'd0);
        for (int c = 0; c < 7; c++) begin
            if (c < 2) expect_beat("s2_pre", PRE_W, 4'b0101);
            else expect_idle("s2_gap");
            chk("s2_done", 32'(done), (c == 6) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // len=4, ready pattern 1,0,0 repeating
        nw        = 0;
        stalled   = 1'b0;
        seen_done = 1'b0;
        start_burst(16'd4);
        for (int c = 0; c < 60 && !seen_done; c++) begin
            if (stalled) begin
                chk("s3_hold_data", tx_data, prev_d);
                chk("s3_hold_k", 32'(tx_k), 32'(prev_k));
            end
            if (done) seen_done = 1'b1;
            ready = (c % 3 == 0);
            if (tx_valid && ready && tx_k == 4'h0 && nw < 8) begin
                words[nw] = tx_data;
                nw++;
            end
            stalled = tx_valid && !ready;
            prev_d  = tx_data;
            prev_k  = tx_k;
            @(negedge clk);
        end
        ready = 1'b1;
        chk("s3_done_seen", 32'(seen_done), 32'd1);
        chk("s3_nwords", 32'(nw), 32'd4);
        for (int i = 0; i < 4; i++) chk("s3_word", words[i], g[i]);

        // abort while second word is stalled
        start_burst(16'd4);
        expect_beat("s4_pre", PRE_W, 4'b0101);
        @(negedge clk);
        @(negedge clk);
        expect_beat("s4_w0", g[0], 4'h0);
        @(negedge clk);
        expect_beat("s4_w1", g[1], 4'h0);
        ready = 1'b0;
        @(negedge clk);
        expect_beat("s4_w1_held", g[1], 4'h0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ready = 1'b1;
        expect_idle("s4_after_abort");
        for (int c = 0; c < 4; c++) begin
            chk("s4_gap_done", 32'(done), 32'd0);
            chk("s4_gap_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        chk("s4_done", 32'(done), 32'd1);
        chk("s4_aborted", 32'(aborted), 32'd1);
        @(negedge clk);
        chk("s4_done_clr", 32'(done), 32'd0);
        chk("s4_aborted_clr", 32'(aborted), 32'd0);
        chk("s4_busy_clr", 32'(busy), 32'd0);

        // reset mid-PRBS, then restart
        start_burst(16'd5);
        @(negedge clk);
        @(negedge clk);
        expect_beat("s5_w0", g[0], 4'h0);
        @(negedge clk);
        expect_beat("s5_w1", g[1], 4'h0);
        #2 rst_n = 1'b0;
        #1;
        expect_idle("s5_async");
        chk("s5_async_busy", 32'(busy), 32'd0);
        chk("s5_async_done", 32'(done), 32'd0);
        chk("s5_async_abt", 32'(aborted), 32'd0);
        @(negedge clk);
        expect_idle("s5_in_rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("s5_rel_busy", 32'(busy), 32'd0);
        start_burst(16'd2);
        expect_beat("s5_pre", PRE_W, 4'b0101);
        @(negedge clk);
        @(negedge clk);
        expect_beat("s5_first", g[0], 4'h0);
        @(negedge clk);
        expect_beat("s5_second", g[1], 4'h0);
        seen_done = 1'b0;
        for (int c = 0; c < 12 && !seen_done; c++) begin
            if (done) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("s5_done_seen", 32'(seen_done), 32'd1);

        // back-to-back with start held
        nw        = 0;
        ndone     = 0;
        nidle     = 0;
        start     = 1'b1;
        burst_len = 16'd2;
        @(negedge clk);
        for (int c = 0; c < 40 && ndone < 2; c++) begin
            if (tx_valid && ready && tx_k == 4'h0 && nw < 8) begin
                words[nw] = tx_data;
                nw++;
            end
            if (!busy && ndone == 1) nidle++;
            if (done) ndone++;
            if (ndone == 2) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("s6_ndone", 32'(ndone), 32'd2);
        chk("s6_idle_gap", 32'(nidle), 32'd1);
        chk("s6_nwords", 32'(nw), 32'd4);
        for (int i = 0; i < 4; i++) chk("s6_word", words[i], g[i % 2]);
        chk("s6_idle_after", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/lfsr_tx_sched.md
LFSR_TX_SCHED -- requirements
Module: lfsr_tx_sched

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- P_LFSR_INIT, 16'hA076, LFSR seed loaded at every burst start.
- P_PREAMBLE_WORD, 32'h50BC50BC, word sent in each preamble beat.
- P_PREAMBLE_CNT, 2, number of preamble beats (minimum 1).
- P_GAP_CYCLES, 4, idle cycles after a burst (minimum 1).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- i_clk, in, 1, sole clock.
- i_rst_n, in, 1, reset; asynchronous assert, active-low.
- i_start, in, 1, burst request; sampled only in IDLE.
- i_burst_len, in, 16, number of PRBS words in the burst; latched on start.
- i_abort, in, 1, terminates the current burst.
- o_tx_data, out, 32, transmit word.
- o_tx_charisk, out, 4, per-byte K flag.
- o_tx_valid, out, 1, o_tx_data is valid.
- i_tx_ready, in, 1, downstream accepts the word.
- o_busy, out, 1, high in every state except IDLE.
- o_done, out, 1, one-cycle pulse at end of burst.
- o_aborted, out, 1, one-cycle pulse, coincident with o_done when the burst ended by abort.

Function
REQ-003 The FSM SHALL have the states IDLE, PRE, PRBS, GAP and DONE.
REQ-004 In IDLE, i_start=1 SHALL latch i_burst_len, reseed the LFSR state to P_LFSR_INIT and enter PRE on the next cycle.
REQ-005 PRE SHALL present P_PREAMBLE_WORD with o_tx_charisk=4'b0101 and o_tx_valid=1 for P_PREAMBLE_CNT accepted beats.
- At the last accepted beat, the FSM SHALL go to PRBS if the latched length is nonzero, else to GAP.
REQ-006 PRBS SHALL present LFSR words with o_tx_charisk=0 and o_tx_valid=1.
- A beat is accepted when o_tx_valid&i_tx_ready.
- After exactly latched-length accepted words, the FSM SHALL go to GAP.
REQ-007 LFSR step: with state s[15:0], form w[47:32]=s and, for i=0..31, w[31-i]=w[47-i]^w[46-i]^w[45-i]^w[33-i].
- The output word is w[31:0]; the next state is w[15:0].
REQ-008 The LFSR SHALL advance only on an accepted PRBS beat.
- The first PRBS word SHALL be the step output of P_LFSR_INIT.
REQ-009 While o_tx_valid=1 and i_tx_ready=0, o_tx_data and o_tx_charisk SHALL hold stable (no drop, no change).
REQ-010 GAP SHALL hold o_tx_valid=0 for P_GAP_CYCLES cycles, then enter DONE.
REQ-011 DONE SHALL last one cycle: it asserts o_done, then returns to IDLE.
- i_start in DONE SHALL be ignored.
REQ-012 i_abort=1 in PRE or PRBS SHALL force GAP on the next cycle.
- o_tx_valid SHALL deassert that next cycle even if the held beat was not accepted (the only exception to REQ-009).
- The burst SHALL set an abort flag; o_aborted SHALL pulse with o_done.
- i_abort in IDLE, GAP or DONE SHALL be ignored.
REQ-013 If i_abort and an accepting handshake occur in the same cycle, the beat SHALL count as delivered and the abort SHALL still take effect.
REQ-014 The word counter SHALL be 16-bit.
- i_burst_len=16'hFFFF SHALL deliver 65535 words with no wrap before GAP.
REQ-015 When o_tx_valid=0, o_tx_data SHALL be 32'h0 and o_tx_charisk SHALL be 4'h0.
REQ-016 Outputs SHALL be registered; first valid beat one cycle after start is sampled.

Reset
REQ-017 i_rst_n=0 SHALL asynchronously force the following, from any state including mid-burst with valid held:
- state=IDLE;
- LFSR state=P_LFSR_INIT;
- counters=0;
- o_tx_data=0, o_tx_charisk=0, o_tx_valid=0, o_busy=0, o_done=0, o_aborted=0.
REQ-018 Reset release SHALL be synchronous to i_clk.
- The first cycle after release SHALL be in IDLE.

Structure
REQ-019 A shared package SHALL hold:
- the FSM state encoding;
- the default seed 16'hA076;
- the K-character mask 4'b0101;
- the default preamble word.
REQ-020 The step function SHALL be one sub-module, lfsr_step: purely combinational, 16-bit state in, 32-bit word and 16-bit next state out.
- The scheduler SHALL own the state register.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Start with len=3 and ready tied high -> 2 preamble beats (charisk 0101), then 3 PRBS words equal to the golden model, then 4 idle cycles, then o_done for 1 cycle; o_busy high for exactly 10 cycles.
- Start with len=0 -> 2 preamble beats, then GAP, then done; no charisk=0 valid beat.
- Len=4 with ready toggling 1,0,0,1,... -> data stable across stalls and the word sequence identical to the no-stall run.
- Abort while the 2nd PRBS beat is stalled -> valid low next cycle, 4 gap cycles, o_done and o_aborted pulse together.
- Reset asserted mid-PRBS, then a new start -> all outputs 0 during reset, and the first PRBS word again equals step(16'hA076).
- Back-to-back bursts with start held high -> the second burst begins from IDLE after DONE, reseeded, and produces identical words.
